// File: rtl/encoded_event_fifo.sv
// encoded_event_fifo: detects new request events from a 4-to-2 priority
// encoder and queues the 2-bit codes in a first-word-fall-through FIFO with a
// ready/valid output side and a saturating counter of overflow drops.
module encoded_event_fifo #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_y1,
  input  logic                       in_y0,
  input  logic                       in_valid,
  output logic [1:0]                 out_code,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [1:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             prev_valid;
  logic [1:0]       prev_code;

  logic [1:0] code;
  logic       event_hit;
  logic       pop;
  logic       push;
  logic       drop;

  assign code      = {in_y1, in_y0};
  assign event_hit = in_valid & (~prev_valid | (code != prev_code));

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign out_valid = ~empty;
  assign out_code  = out_valid ? mem[rd_ptr] : 2'b00;

  assign pop  = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = event_hit & (~full | pop);
  assign drop = event_hit & full & ~pop;

  // Storage array: written on push, never cleared.
  // NOTE: the data array carries no reset; count/pointers alone decide which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= code;
    end
  end

  // Control state: edge detection history, pointers, occupancy and drops.
  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
      prev_code  <= 2'b00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_cnt   <= '0;
    end else begin
      prev_valid <= in_valid;
      prev_code  <= code;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_encoded_event_fifo.sv
// Directed bench for encoded_event_fifo (DEPTH=4, DROP_W=8).
module tb_encoded_event_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_y1;
  logic       in_y0;
  logic       in_valid;
  logic [1:0] out_code;
  logic       out_valid;
  logic       out_ready;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic [7:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  encoded_event_fifo #(.DEPTH(4), .DROP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_y1     (in_y1),
    .in_y0     (in_y0),
    .in_valid  (in_valid),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] c);
    in_valid = v;
    {in_y1, in_y0} = c;
  endtask

  task automatic check_status(input string tag, input logic [2:0] c, input logic [7:0] d);
    check({tag, "_count"}, 32'(count), 32'(c));
    check({tag, "_drop"}, 32'(drop_cnt), 32'(d));
    check({tag, "_empty"}, 32'(empty), 32'(c == 3'd0));
    check({tag, "_full"}, 32'(full), 32'(c == 3'd4));
    check({tag, "_ovalid"}, 32'(out_valid), 32'(c != 3'd0));
  endtask

  initial begin
    logic [1:0] fill_codes [4];
    logic [1:0] extra_codes [3];
    logic [1:0] after_codes [4];
    fill_codes  = '{2'b01, 2'b10, 2'b11, 2'b00};
    extra_codes = '{2'b01, 2'b10, 2'b11};
    after_codes = '{2'b10, 2'b11, 2'b00, 2'b01};

    rst = 1'b1; out_ready = 1'b0; drive(1'b0, 2'b00);
    tick(); tick();
    rst = 1'b0;
    check_status("reset", 3'd0, 8'd0);
    check("reset_code", 32'(out_code), 32'd0);

    // Idle with valid low; codes toggle but must not create events.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'(i));
      tick();
      check_status("idle", 3'd0, 8'd0);
      check("idle_code", 32'(out_code), 32'd0);
    end

    // Four distinct codes, no consumer: FIFO fills.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i));
      tick();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_head", 32'(out_code), 32'd0);
    end
    check_status("filled", 3'd4, 8'd0);

    // Drain in order, one per cycle.
    drive(1'b0, 2'b11);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_code", 32'(out_code), 32'(i));
      tick();
    end
    check_status("drained", 3'd0, 8'd0);
    check("drained_code", 32'(out_code), 32'd0);

    // Steady valid with one code: a single event.
    out_ready = 1'b0;
    drive(1'b1, 2'b10);
    for (int i = 0; i < 8; i++) tick();
    check_status("steady", 3'd1, 8'd0);
    check("steady_code", 32'(out_code), 32'd2);
    drive(1'b0, 2'b10);
    out_ready = 1'b1;
    tick();
    check_status("steady_drain", 3'd0, 8'd0);
    out_ready = 1'b1;
    tick();
    check("ready_while_empty", 32'(count), 32'd0);

    // Fill, then overflow with three more distinct events.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill_codes[i]);
      tick();
    end
    check_status("full2", 3'd4, 8'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, extra_codes[i]);
      tick();
      check("ovf_drop", 32'(drop_cnt), 32'(i + 1));
      check("ovf_hold_head", 32'(out_code), 32'd1);
    end
    check_status("overflow", 3'd4, 8'd3);

    // Full with pop and a new event in the same cycle: accepted.
    drive(1'b1, 2'b01);
    out_ready = 1'b1;
    tick();
    check_status("full_pop_push", 3'd4, 8'd3);
    drive(1'b0, 2'b01);
    for (int i = 0; i < 4; i++) begin
      check("after_code", 32'(out_code), 32'(after_codes[i]));
      tick();
    end
    check_status("after_drain", 3'd0, 8'd3);

    // Two queued entries, then reset while events arrive.
    out_ready = 1'b0;
    drive(1'b1, 2'b10); tick();
    drive(1'b1, 2'b11); tick();
    check("pre_rst_count", 32'(count), 32'd2);
    drive(1'b1, 2'b01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_status("mid_reset", 3'd0, 8'd0);
    check("mid_reset_code", 32'(out_code), 32'd0);
    tick();
    check_status("post_reset_event", 3'd1, 8'd0);
    check("post_reset_code", 32'(out_code), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    check_status("post_reset_steady", 3'd1, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoded_event_fifo.md
# encoded_event_fifo

Sequential stage directly downstream of the 4-to-2 priority encoder. It watches the encoder's `Y1`/`Y0`/`valid` outputs and detects each new request event, meaning `valid` rising or the encoded code changing while `valid` stays high. It queues the 2-bit codes in a small first-in-first-out (FIFO) buffer and presents them to a consumer over a ready/valid handshake. It also counts events lost to overflow.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `DROP_W`, default 8: width of the saturating drop counter.

Ports:
- `clk` — input, 1: single clock; all state updates on rising edge.
- `rst` — input, 1: reset, synchronous and active-high.
- `in_y1` — input, 1: encoder `Y1` (code MSB).
- `in_y0` — input, 1: encoder `Y0` (code LSB).
- `in_valid` — input, 1: encoder `valid`.
- `out_code` — output, 2: head-of-FIFO code; forced 2'b00 when empty.
- `out_valid` — output, 1: FIFO non-empty.
- `out_ready` — input, 1: consumer accepts `out_code` this cycle.
- `full` — output, 1: count == DEPTH.
- `empty` — output, 1: count == 0.
- `count` — output, $clog2(DEPTH)+1: current occupancy.
- `drop_cnt` — output, DROP_W: events discarded because the FIFO was full; saturates at all-ones.

## Operation
- Input code is {in_y1, in_y0}. Registers `prev_valid` and `prev_code` sample `in_valid` and the code every cycle.
- Event (combinational) = in_valid & (~prev_valid | (code != prev_code)).
- Event examples:
  - Steady valid with an unchanged code produces no further events.
  - in_valid low never produces an event, regardless of code.
- Pop = out_valid & out_ready.
- Push = event & (~full | pop).
  - When full with a simultaneous pop, the push is accepted and count is unchanged.
- Drop = event & full & ~pop: drop_cnt += 1, holding at 2^DROP_W−1.
- Storage:
  - Circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping DEPTH−1 → 0 naturally.
  - The separate `count` register is the source of full and empty.
- Count update:
  - Push only: count+1.
  - Pop only: count−1.
  - Both: unchanged.
  - Neither: unchanged.
- First-word-fall-through: `out_code` = mem[rd_ptr] while out_valid; otherwise 2'b00.
- Ordering is strict FIFO; entries are never reordered or merged.

## Timing
- Reset values (taking effect on the clk edge with rst=1):
  - count=0, wr_ptr=rd_ptr=0, prev_valid=0, prev_code=0, drop_cnt=0.
  - Hence out_valid=0, out_code=2'b00, empty=1, full=0.
- Reset mid-operation:
  - All queued entries are discarded and drop_cnt is cleared.
  - Inputs seen during reset cycles are neither pushed nor dropped.
  - prev_* hold reset values.
- The first cycle after reset with in_valid=1 produces an event, because prev_valid=0.
- Latency: an event in cycle n is written at the end of cycle n; out_valid and out_code reflect it in cycle n+1 if the FIFO was empty.
- Pop takes effect at the edge; the next entry appears in the following cycle.
- Throughput: one push and one pop per cycle sustained.
- Handshake:
  - out_code is stable while out_valid=1 and out_ready=0.
  - out_ready while empty has no effect.
- Simultaneous push and pop on an empty FIFO cannot occur, since no pop is possible when empty. The push lands and out_valid rises next cycle.
- drop_cnt updates at the same edge where the drop is decided.

## Test plan
- Reset, then in_valid=0 for 5 cycles: out_valid=0, out_code=00, empty=1, count=0, drop_cnt=0 throughout.
- Drive I-pattern codes 00,01,10,11 with valid=1, one per cycle, out_ready=0:
  - count reaches 4 and full=1.
  - Then out_ready=1 pops 00,01,10,11 in order on consecutive cycles; empty=1 after.
- Hold valid=1, code=10 for 8 cycles: exactly one entry (10) queued, count=1.
- Fill the FIFO (DEPTH=4) with out_ready=0, then present 3 more distinct events:
  - drop_cnt=3 and count=4.
  - Contents remain the first four codes.
- Full FIFO, out_ready=1, a new event (code 01) in the same cycle: push accepted, count stays 4, and 01 emerges as the last of the next four pops.
- With 2 entries queued, assert rst for 1 cycle while events arrive:
  - Next cycle count=0, drop_cnt=0, out_valid=0.
  - Steady valid=1 afterwards yields one fresh event.
